// File: rtl/dino_pkg.sv
// Shared motion-state encoding and screen geometry for the dinosaur sprite path.
package dino_pkg;

    typedef enum logic [1:0] {
        StGround = 2'd0,
        StAir    = 2'd1,
        StDuck   = 2'd2
    } dino_state_e;

    localparam int unsigned SCREEN_GROUND_Y = 402;
    localparam int unsigned SCREEN_X0       = 80;

endpackage

// File: rtl/dino_sprite_rom.sv
// Constant run/duck sprite bitmaps with a registered read; final stage of the pixel pipeline.
module dino_sprite_rom #(
    parameter int unsigned SPR_W  = 82,
    parameter int unsigned SPR_H  = 88,
    parameter int unsigned DUCK_H = 44,
    parameter int unsigned RR_W   = 7,
    parameter int unsigned RC_W   = 7
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_in_box,
    input  logic            i_duck,
    input  logic [RR_W-1:0] i_row,
    input  logic [RC_W-1:0] i_col,
    output logic            o_px
);

    int   w_row;
    int   w_col;
    logic w_bit;
    logic r_px;

    function automatic logic in_rect(input int r, input int c, input int r0, input int r1,
                                     input int c0, input int c1);
        return (r >= r0) && (r <= r1) && (c >= c0) && (c <= c1);
    endfunction

    // Bitmaps are described as filled rectangles: head, body, tail and legs.
    always_comb begin
        w_row = int'(i_row);
        w_col = int'(i_col);
        w_bit = 1'b0;
        if (i_duck) begin
            if ((w_row < int'(DUCK_H)) && (w_col < int'(SPR_W))) begin
                w_bit = (in_rect(w_row, w_col, 0, 17, 50, 81) &&
                         !in_rect(w_row, w_col, 4, 9, 62, 67))
                      || in_rect(w_row, w_col, 8, 31, 0, 61)
                      || in_rect(w_row, w_col, 32, 43, 16, 27)
                      || in_rect(w_row, w_col, 32, 43, 40, 51);
            end
        end else begin
            if ((w_row < int'(SPR_H)) && (w_col < int'(SPR_W))) begin
                w_bit = (in_rect(w_row, w_col, 0, 29, 44, 81) &&
                         !in_rect(w_row, w_col, 8, 13, 56, 61))
                      || in_rect(w_row, w_col, 30, 59, 10, 61)
                      || in_rect(w_row, w_col, 40, 51, 0, 9)
                      || in_rect(w_row, w_col, 60, 87, 16, 27)
                      || in_rect(w_row, w_col, 60, 87, 40, 51);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_px <= 1'b0;
        end else begin
            r_px <= i_in_box & w_bit;
        end
    end

    assign o_px = r_px;

endmodule

// File: rtl/dino_jump_unit.sv
// Dinosaur vertical-motion FSM (jump, duck, fast-fall, double jump) with hit box and
// a two-stage sprite pixel pipeline for the VGA scan.
module dino_jump_unit
    import dino_pkg::*;
#(
    parameter int unsigned SPR_W        = 82,
    parameter int unsigned SPR_H        = 88,
    parameter int unsigned DUCK_H       = 44,
    parameter int unsigned X0           = SCREEN_X0,
    parameter int unsigned GROUND_Y     = SCREEN_GROUND_Y,
    parameter int unsigned AIR_T        = 60,
    parameter int unsigned ARC_DIV      = 6,
    parameter int unsigned ALLOW_DOUBLE = 1,
    parameter int unsigned H_W          = 10
) (
    input  logic           clk,
    input  logic           RESET,
    input  logic           fresh,
    input  logic           game_status,
    input  logic           START,
    input  logic           button_jump,
    input  logic           button_duck,
    input  logic [8:0]     row_addr,
    input  logic [9:0]     col_addr,
    output logic           px,
    output logic           airborne,
    output logic           ducking,
    output logic [H_W-1:0] height,
    output logic [H_W-1:0] hit_top,
    output logic [H_W-1:0] hit_bottom
);

    localparam int unsigned T_W  = $clog2(AIR_T + 1);
    localparam int unsigned P_W  = 2 * T_W;
    localparam int unsigned RR_W = $clog2(SPR_H);
    localparam int unsigned RC_W = $clog2(SPR_W);

    logic r_fresh_s1;
    logic r_fresh_s2;
    logic r_fresh_s3;
    logic w_tick;

    dino_state_e    r_state;
    dino_state_e    w_state_d;
    logic [T_W-1:0] r_t;
    logic [T_W-1:0] w_t_d;
    logic [1:0]     r_jumps;
    logic [1:0]     w_jumps_d;
    logic           r_jump_prev;
    logic [T_W:0]   w_t_step;
    logic           w_jump_edge;
    logic           w_can_double;

    logic [P_W-1:0] w_prod;
    logic [H_W-1:0] w_height;
    logic [H_W-1:0] w_active_h;
    logic [H_W-1:0] r_height;
    logic [H_W-1:0] r_hit_top;
    logic [H_W-1:0] r_hit_bottom;
    logic           r_pose_duck;

    logic [H_W-1:0]  w_row;
    logic            w_in_box;
    logic            r_in_box;
    logic            r_rom_duck;
    logic [RR_W-1:0] r_rom_row;
    logic [RC_W-1:0] r_rom_col;

    // fresh is asynchronous: two flops to synchronise, a third to find its falling edge.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_fresh_s1 <= 1'b0;
            r_fresh_s2 <= 1'b0;
            r_fresh_s3 <= 1'b0;
        end else begin
            r_fresh_s1 <= fresh;
            r_fresh_s2 <= r_fresh_s1;
            r_fresh_s3 <= r_fresh_s2;
        end
    end

    assign w_tick = r_fresh_s3 & ~r_fresh_s2;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_state     <= StGround;
            r_t         <= '0;
            r_jumps     <= '0;
            r_jump_prev <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_t     <= w_t_d;
            r_jumps <= w_jumps_d;
            if (w_tick) begin
                r_jump_prev <= button_jump;
            end
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_t_d        = r_t;
        w_jumps_d    = r_jumps;
        w_t_step     = {1'b0, r_t} + (button_duck ? (T_W+1)'(2) : (T_W+1)'(1));
        w_jump_edge  = button_jump & ~r_jump_prev;
        w_can_double = (ALLOW_DOUBLE != 0) && w_jump_edge && (r_jumps == 2'd1)
                       && (r_t > T_W'(AIR_T / 2));
        if (w_tick) begin
            if (!game_status) begin
                if (START) begin
                    w_state_d = StGround;
                    w_t_d     = '0;
                    w_jumps_d = '0;
                end
            end else begin
                case (r_state)
                    StGround, StDuck: begin
                        if (button_jump) begin
                            w_state_d = StAir;
                            w_t_d     = T_W'(1);
                            w_jumps_d = 2'd1;
                        end else if (button_duck) begin
                            w_state_d = StDuck;
                        end else begin
                            w_state_d = StGround;
                        end
                    end
                    StAir: begin
                        // Landing is checked first so it beats a same-tick double jump.
                        if (w_t_step >= (T_W+1)'(AIR_T)) begin
                            w_state_d = StGround;
                            w_t_d     = '0;
                            w_jumps_d = '0;
                        end else if (w_can_double) begin
                            w_t_d     = T_W'(AIR_T) - r_t;
                            w_jumps_d = 2'd2;
                        end else begin
                            w_t_d = T_W'(w_t_step);
                        end
                    end
                    default: begin
                        w_state_d = StGround;
                        w_t_d     = '0;
                        w_jumps_d = '0;
                    end
                endcase
            end
        end
    end

    // Parabolic arc, zero at t=0 and t=AIR_T.
    assign w_prod     = P_W'(r_t) * P_W'(T_W'(AIR_T) - r_t);
    assign w_height   = H_W'(w_prod / P_W'(ARC_DIV));
    assign w_active_h = (r_state == StDuck) ? H_W'(DUCK_H) : H_W'(SPR_H);

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_height     <= '0;
            r_hit_top    <= H_W'(GROUND_Y) - H_W'(SPR_H);
            r_hit_bottom <= H_W'(GROUND_Y);
            r_pose_duck  <= 1'b0;
        end else begin
            r_height     <= w_height;
            r_hit_top    <= H_W'(GROUND_Y) - w_height - w_active_h;
            r_hit_bottom <= H_W'(GROUND_Y) - w_height;
            r_pose_duck  <= (r_state == StDuck);
        end
    end

    assign w_row    = H_W'(row_addr);
    assign w_in_box = (w_row >= r_hit_top) && (w_row < r_hit_bottom)
                      && (col_addr >= 10'(X0)) && (col_addr < 10'(X0 + SPR_W));

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_in_box   <= 1'b0;
            r_rom_duck <= 1'b0;
            r_rom_row  <= '0;
            r_rom_col  <= '0;
        end else begin
            r_in_box   <= w_in_box;
            r_rom_duck <= r_pose_duck;
            r_rom_row  <= RR_W'(w_row - r_hit_top);
            r_rom_col  <= RC_W'(col_addr - 10'(X0));
        end
    end

    dino_sprite_rom #(
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H),
        .DUCK_H (DUCK_H),
        .RR_W   (RR_W),
        .RC_W   (RC_W)
    ) u_rom (
        .i_clk    (clk),
        .i_rst    (RESET),
        .i_in_box (r_in_box),
        .i_duck   (r_rom_duck),
        .i_row    (r_rom_row),
        .i_col    (r_rom_col),
        .o_px     (px)
    );

    assign airborne   = (r_state == StAir);
    assign ducking    = (r_state == StDuck);
    assign height     = r_height;
    assign hit_top    = r_hit_top;
    assign hit_bottom = r_hit_bottom;

endmodule

// File: tb/tb_dino_jump_unit.sv
// Directed bench for dino_jump_unit: arithmetic motion model checked every settled cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_dino_jump_unit;

    logic       clk;
    logic       RESET;
    logic       fresh;
    logic       game_status;
    logic       START;
    logic       button_jump;
    logic       button_duck;
    logic [8:0] row_addr;
    logic [9:0] col_addr;

    logic       px, airborne, ducking;
    logic [9:0] height, hit_top, hit_bottom;
    logic       nd_px, nd_airborne, nd_ducking;
    logic [9:0] nd_height, nd_hit_top, nd_hit_bottom;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 = ground, 1 = air, 2 = duck.
    int m_mode, m_t, m_jumps;
    bit m_prev;
    bit settled;

    dino_jump_unit u_dut (
        .clk         (clk),
        .RESET       (RESET),
        .fresh       (fresh),
        .game_status (game_status),
        .START       (START),
        .button_jump (button_jump),
        .button_duck (button_duck),
        .row_addr    (row_addr),
        .col_addr    (col_addr),
        .px          (px),
        .airborne    (airborne),
        .ducking     (ducking),
        .height      (height),
        .hit_top     (hit_top),
        .hit_bottom  (hit_bottom)
    );

    dino_jump_unit #(.ALLOW_DOUBLE(0)) u_dut_nd (
        .clk         (clk),
        .RESET       (RESET),
        .fresh       (fresh),
        .game_status (game_status),
        .START       (START),
        .button_jump (button_jump),
        .button_duck (button_duck),
        .row_addr    (row_addr),
        .col_addr    (col_addr),
        .px          (nd_px),
        .airborne    (nd_airborne),
        .ducking     (nd_ducking),
        .height      (nd_height),
        .hit_top     (nd_hit_top),
        .hit_bottom  (nd_hit_bottom)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, exp);
        end
    endtask

    function automatic int m_height();
        return (m_t * (60 - m_t)) / 6;
    endfunction

    function automatic int m_top();
        return 402 - m_height() - ((m_mode == 2) ? 44 : 88);
    endfunction

    function automatic bit m_in_box(input int r, input int c);
        return (r >= m_top()) && (r < 402 - m_height()) && (c >= 80) && (c < 162);
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_t     = 0;
        m_jumps = 0;
        m_prev  = 1'b0;
    endtask

    task automatic model_tick();
        bit edge_j;
        int step;
        edge_j = button_jump && !m_prev;
        step   = button_duck ? 2 : 1;
        if (!game_status) begin
            if (START) begin
                m_mode = 0; m_t = 0; m_jumps = 0;
            end
        end else if (m_mode == 1) begin
            if (m_t + step >= 60) begin
                m_mode = 0; m_t = 0; m_jumps = 0;
            end else if (edge_j && m_jumps == 1 && m_t > 30) begin
                m_t = 60 - m_t; m_jumps = 2;
            end else begin
                m_t = m_t + step;
            end
        end else if (button_jump) begin
            m_mode = 1; m_t = 1; m_jumps = 1;
        end else begin
            m_mode = button_duck ? 2 : 0;
        end
        m_prev = button_jump;
    endtask

    task automatic do_tick();
        @(negedge clk);
        settled = 1'b0;
        fresh   = 1'b1;
        repeat (3) @(negedge clk);
        fresh = 1'b0;
        repeat (8) @(negedge clk);
        model_tick();
        settled = 1'b1;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        settled = 1'b0;
        RESET   = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        RESET = 1'b0;
        repeat (2) @(negedge clk);
        settled = 1'b1;
    endtask

    task automatic px_at(input string nm, input int r, input int c, input int exp);
        @(negedge clk);
        row_addr = 9'(r);
        col_addr = 10'(c);
        repeat (4) @(negedge clk);
        check(nm, px, exp);
    endtask

    // Continuous comparison against the model whenever no tick is in flight.
    initial begin
        int prev_r, prev_c, stable;
        prev_r = 0; prev_c = 0; stable = 0;
        forever begin
            @(negedge clk);
            if (int'(row_addr) != prev_r || int'(col_addr) != prev_c) stable = 0;
            else if (stable < 3) stable++;
            prev_r = int'(row_addr);
            prev_c = int'(col_addr);
            if (settled && !RESET) begin
                check("airborne", airborne, (m_mode == 1) ? 1 : 0);
                check("ducking", ducking, (m_mode == 2) ? 1 : 0);
                check("height", height, m_height());
                check("hit_top", hit_top, m_top());
                check("hit_bottom", hit_bottom, 402 - m_height());
                if (stable >= 3 && !m_in_box(prev_r, prev_c)) check("px_outside", px, 0);
            end
        end
    end

    initial begin
        RESET = 1'b1; fresh = 1'b0; game_status = 1'b1; START = 1'b0;
        button_jump = 1'b0; button_duck = 1'b0; row_addr = '0; col_addr = '0;
        settled = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_height", height, 0);
        check("rst_hit_top", hit_top, 314);
        check("rst_hit_bottom", hit_bottom, 402);
        check("rst_airborne", airborne, 0);
        check("rst_ducking", ducking, 0);
        check("rst_px", px, 0);
        check("rst_nd_top", nd_hit_top, 314);
        check("rst_nd_bottom", nd_hit_bottom, 402);
        check("rst_nd_ducking", nd_ducking, 0);
        check("rst_nd_px", nd_px, 0);
        RESET = 1'b0;
        repeat (2) @(negedge clk);
        settled = 1'b1;

        // Full arc, with a jump edge on the landing tick.
        button_jump = 1'b1; do_tick(); button_jump = 1'b0;
        check("arc_t1_air", airborne, 1);
        check("arc_t1_h", height, 9);
        do_ticks(29);
        check("arc_peak_h", height, 150);
        check("arc_peak_top", hit_top, 164);
        check("arc_peak_bottom", hit_bottom, 252);
        do_ticks(29);
        check("arc_t59_h", height, 9);
        button_jump = 1'b1; do_tick();
        check("land_wins_air", airborne, 0);
        check("land_wins_h", height, 0);
        button_jump = 1'b0; do_tick();
        check("ground_stays", airborne, 0);

        // Double jump at t=40, then a second edge that must be ignored.
        do_reset();
        button_jump = 1'b1; do_tick(); button_jump = 1'b0;
        do_ticks(39);
        check("dbl_pre_h", height, 133);
        button_jump = 1'b1; do_tick();
        check("dbl_h", height, 133);
        check("nd_no_dbl_h", nd_height, 129);
        check("nd_no_dbl_air", nd_airborne, 1);
        do_tick(); button_jump = 1'b0;
        check("dbl_held_h", height, 136);
        do_ticks(14);
        check("dbl_t35_h", height, 145);
        button_jump = 1'b1; do_tick(); button_jump = 1'b0;
        check("dbl_second_ignored", height, 144);
        do_ticks(23);
        check("dbl_t59_air", airborne, 1);
        do_tick();
        check("dbl_land_40", airborne, 0);

        // Edge during the rising phase is not a double jump.
        do_reset();
        button_jump = 1'b1; do_tick(); button_jump = 1'b0;
        do_ticks(18);
        button_jump = 1'b1; do_tick(); button_jump = 1'b0;
        check("rising_edge_ignored", height, 133);

        // Ducking, sprite pixels, and fast fall.
        do_reset();
        button_duck = 1'b1; do_tick();
        check("duck_flag", ducking, 1);
        check("duck_top", hit_top, 358);
        px_at("duck_px_leg", 400, 100, 1);
        button_duck = 1'b0; do_tick();
        check("unduck_top", hit_top, 314);
        px_at("run_px_leg", 400, 100, 1);
        px_at("run_px_col79", 400, 79, 0);
        px_at("run_px_col162", 400, 162, 0);
        px_at("run_px_eye", 324, 140, 0);
        px_at("run_px_tail", 359, 85, 1);
        px_at("run_px_corner", 314, 80, 0);
        row_addr = '0; col_addr = '0;
        button_jump = 1'b1; do_tick(); button_jump = 1'b0;
        do_ticks(29);
        button_duck = 1'b1;
        do_ticks(14);
        check("ff_t58_h", height, 19);
        check("ff_t58_air", airborne, 1);
        do_tick();
        check("ff_land_air", airborne, 0);
        check("ff_land_duck", ducking, 0);
        do_tick();
        check("ff_then_duck", ducking, 1);
        button_duck = 1'b0; do_tick();

        // Pause freezes motion; START while paused returns to ground.
        do_reset();
        button_jump = 1'b1; do_tick(); button_jump = 1'b0;
        do_ticks(24);
        check("pause_pre_h", height, 145);
        game_status = 1'b0;
        do_ticks(10);
        check("pause_frozen_h", height, 145);
        check("pause_frozen_air", airborne, 1);
        START = 1'b1; do_tick(); START = 1'b0;
        check("start_air", airborne, 0);
        check("start_h", height, 0);
        game_status = 1'b1;

        // Asynchronous reset clears the pixel immediately.
        px_at("pre_rst_px", 400, 100, 1);
        @(negedge clk);
        settled = 1'b0;
        RESET = 1'b1;
        #1;
        check("async_rst_px", px, 0);
        model_reset();
        repeat (2) @(negedge clk);
        RESET = 1'b0;
        row_addr = '0; col_addr = '0;
        repeat (2) @(negedge clk);
        settled = 1'b1;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
